// File: rtl/icache_refill_if.sv
// ---------------------------------------------------------------------------
// icache_refill_if
//   Bundles the refill engine's handshakes and buses: miss request in, memory
//   read request/response, and the data/tag array write port.
//   master : the refill engine (drives miss_ready, mem_req_*, mem_resp_ready,
//            laddra/dina/ena/tag_*, refill_done/refill_err)
//   slave  : the surrounding fetch unit / memory / arrays
// ---------------------------------------------------------------------------
interface icache_refill_if #(
    parameter int unsigned WNUM        = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LADDR_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH  = 32
);
    localparam int unsigned OFF       = $clog2(WNUM * DATA_WIDTH / 8);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - LADDR_WIDTH - OFF;

    logic                   miss_valid;
    logic                   miss_ready;
    logic [ADDR_WIDTH-1:0]  miss_addr;
    logic                   flush;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_resp_valid;
    logic                   mem_resp_ready;
    logic [DATA_WIDTH-1:0]  mem_resp_data;
    logic                   mem_resp_err;
    logic [LADDR_WIDTH-1:0] laddra;
    logic [DATA_WIDTH-1:0]  dina [WNUM];
    logic                   ena;
    logic                   tag_we;
    logic [TAG_WIDTH-1:0]   tag_wdata;
    logic                   refill_done;
    logic                   refill_err;

    modport master (
        input  miss_valid, miss_addr, flush, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_err,
        output miss_ready, mem_req_valid, mem_req_addr, mem_resp_ready,
               laddra, dina, ena, tag_we, tag_wdata, refill_done, refill_err
    );

    modport slave (
        output miss_valid, miss_addr, flush, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_err,
        input  miss_ready, mem_req_valid, mem_req_addr, mem_resp_ready,
               laddra, dina, ena, tag_we, tag_wdata, refill_done, refill_err
    );
endinterface

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
//   Instruction-cache refill engine. Accepts a miss, issues one line-aligned
//   memory read, gathers WNUM beats into a line buffer, then writes the whole
//   line plus tag in a single cycle. Flushed or errored refills never reach
//   the data memory.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : icache_refill_if.master (miss, memory request/response,
//                data/tag write port, done/error pulses)
// ---------------------------------------------------------------------------
module icache_refill #(
    parameter int unsigned WNUM        = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LADDR_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_refill_if.master   bus
);
    localparam int unsigned OFF       = $clog2(WNUM * DATA_WIDTH / 8);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - LADDR_WIDTH - OFF;
    localparam int unsigned CNT_W     = $clog2(WNUM);

    typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

    state_t                 r_state;
    logic                   r_miss_ready;
    logic                   r_mem_req_valid;
    logic                   r_mem_resp_ready;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_kill;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_buf [WNUM];
    logic [LADDR_WIDTH-1:0] r_laddra;
    logic [TAG_WIDTH-1:0]   r_tag_wdata;
    logic                   r_ena;
    logic                   r_refill_err;

    logic w_last;
    logic w_kill_n;
    logic w_err_n;

    assign w_last   = (r_cnt == CNT_W'(WNUM - 1));
    // A flush or error arriving on the last beat still decides that beat's outcome.
    assign w_kill_n = r_kill | bus.flush;
    assign w_err_n  = r_err | bus.mem_resp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_miss_ready     <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b0;
            r_cnt            <= '0;
            r_kill           <= 1'b0;
            r_err            <= 1'b0;
            r_laddra         <= '0;
            r_tag_wdata      <= '0;
            r_ena            <= 1'b0;
            r_refill_err     <= 1'b0;
            for (int unsigned i = 0; i < WNUM; i++) r_buf[i] <= '0;
        end else begin
            r_ena        <= 1'b0;
            r_refill_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_miss_ready <= 1'b1;
                    if (bus.miss_valid && r_miss_ready) begin
                        r_tag_wdata     <= bus.miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                        r_laddra        <= bus.miss_addr[OFF +: LADDR_WIDTH];
                        r_miss_ready    <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    // An accepted request must have its beats drained, so a
                    // coincident flush only marks the fill as killed.
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid  <= 1'b0;
                        r_mem_resp_ready <= 1'b1;
                        r_cnt            <= '0;
                        r_kill           <= bus.flush;
                        r_err            <= 1'b0;
                        r_state          <= FILL;
                    end else if (bus.flush) begin
                        r_mem_req_valid <= 1'b0;
                        r_miss_ready    <= 1'b1;
                        r_state         <= IDLE;
                    end
                end
                FILL: begin
                    r_kill <= w_kill_n;
                    if (bus.mem_resp_valid) begin
                        r_buf[r_cnt] <= bus.mem_resp_data;
                        r_cnt        <= r_cnt + CNT_W'(1);
                        r_err        <= w_err_n;
                        if (w_last) begin
                            r_mem_resp_ready <= 1'b0;
                            r_cnt            <= '0;
                            if (w_kill_n) begin
                                r_miss_ready <= 1'b1;
                                r_state      <= IDLE;
                            end else if (w_err_n) begin
                                r_refill_err <= 1'b1;
                                r_miss_ready <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_ena   <= 1'b1;
                                r_state <= WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    r_miss_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.miss_ready     = r_miss_ready;
    assign bus.mem_req_valid  = r_mem_req_valid;
    assign bus.mem_req_addr   = {r_tag_wdata, r_laddra, {OFF{1'b0}}};
    assign bus.mem_resp_ready = r_mem_resp_ready;
    assign bus.laddra         = r_laddra;
    assign bus.tag_wdata      = r_tag_wdata;
    assign bus.ena            = r_ena;
    assign bus.tag_we         = r_ena;
    assign bus.refill_done    = r_ena;
    assign bus.refill_err     = r_refill_err;

    for (genvar g = 0; g < int'(WNUM); g++) begin : g_dina
        assign bus.dina[g] = r_buf[g];
    end
endmodule

// File: tb/tb_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_icache_refill
//   Self-checking bench for icache_refill. A negedge monitor records pulses,
//   handshakes and the written line; each test task compares those records
//   with outcomes computed from the address split and refill rules.
// ---------------------------------------------------------------------------
module tb_icache_refill;
    localparam int WNUM = 8;
    localparam int DW   = 32;
    localparam int LW   = 6;
    localparam int AW   = 32;
    localparam int OFF  = $clog2(WNUM * DW / 8);
    localparam int TW   = AW - LW - OFF;
    localparam int LNUM = 1 << LW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_refill_if #(.WNUM(WNUM), .DATA_WIDTH(DW), .LADDR_WIDTH(LW), .ADDR_WIDTH(AW)) ifc ();

    icache_refill #(.WNUM(WNUM), .DATA_WIDTH(DW), .LADDR_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Monitor records
    int n_ena, n_done, n_bad_align, n_err, n_req_hs, n_beats, n_unstable;
    int t_ena, t_err, t_last_beat, t_req_first, t_mr_rise;
    logic [DW-1:0] got_line [WNUM];
    logic [LW-1:0] got_idx;
    logic [TW-1:0] got_tag;
    logic [AW-1:0] got_req_addr, held_addr;
    logic prev_mr = 1'b0, prev_rv = 1'b0;

    logic [DW-1:0] exp_line [WNUM];

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.ena) begin
                n_ena++; t_ena = cyc;
                for (int i = 0; i < WNUM; i++) got_line[i] = ifc.dina[i];
                got_idx = ifc.laddra; got_tag = ifc.tag_wdata;
            end
            if (ifc.refill_done) n_done++;
            if (ifc.tag_we !== ifc.ena || ifc.refill_done !== ifc.ena) n_bad_align++;
            if (ifc.refill_err) begin n_err++; t_err = cyc; end
            if (ifc.mem_req_valid) begin
                if (!prev_rv) begin
                    held_addr = ifc.mem_req_addr;
                    if (t_req_first < 0) t_req_first = cyc;
                end else if (ifc.mem_req_addr !== held_addr) n_unstable++;
                if (ifc.mem_req_ready) begin n_req_hs++; got_req_addr = ifc.mem_req_addr; end
            end
            prev_rv = ifc.mem_req_valid;
            if (ifc.mem_resp_valid && ifc.mem_resp_ready) begin n_beats++; t_last_beat = cyc; end
            if (ifc.miss_ready && !prev_mr) t_mr_rise = cyc;
            prev_mr = ifc.miss_ready;
        end else begin
            prev_mr = 1'b0; prev_rv = 1'b0;
        end
    end

    // Reference address split
    function automatic logic [AW-1:0] m_line_addr(input logic [AW-1:0] a);
        return (a >> OFF) << OFF;
    endfunction
    function automatic logic [LW-1:0] m_idx(input logic [AW-1:0] a);
        return LW'((a >> OFF) % LNUM);
    endfunction
    function automatic logic [TW-1:0] m_tag(input logic [AW-1:0] a);
        return TW'(a >> (OFF + LW));
    endfunction

    function automatic int line_diffs();
        int d = 0;
        for (int i = 0; i < WNUM; i++) if (got_line[i] !== exp_line[i]) d++;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        n_ena = 0; n_done = 0; n_bad_align = 0; n_err = 0; n_req_hs = 0;
        n_beats = 0; n_unstable = 0;
        t_ena = -1; t_err = -1; t_last_beat = -1; t_req_first = -1; t_mr_rise = -1;
        for (int i = 0; i < WNUM; i++) got_line[i] = '0;
        got_idx = '0; got_tag = '0; got_req_addr = '0;
    endtask

    task automatic timeout(input string what);
        n_checks++; n_fail++;
        $display("FAIL timeout_%s: no response within bound, required handshake", what);
    endtask

    // flush_at: -1 none, -2 in REQ before handshake, -3 with handshake, k on beat k.
    // abort_after: return right after beat k is accepted (-1 = run to completion).
    task automatic do_refill(input logic [AW-1:0] addr, input int req_wait, input int max_gap,
                             input int flush_at, input int err_at, input int abort_after,
                             output int t_acc);
        int n;
        t_acc = -1;
        ifc.miss_valid = 1'b1; ifc.miss_addr = addr;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ifc.miss_ready) break;
            if (++n > 200) begin timeout("miss"); ifc.miss_valid = 1'b0; return; end
        end
        tick(); t_acc = cyc; ifc.miss_valid = 1'b0;
        if (flush_at == -2) begin
            repeat (2) tick();
            ifc.flush = 1'b1; tick(); ifc.flush = 1'b0;
            return;
        end
        repeat (req_wait) tick();
        ifc.mem_req_ready = 1'b1;
        if (flush_at == -3) ifc.flush = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ifc.mem_req_valid) break;
            if (++n > 200) begin timeout("req"); ifc.mem_req_ready = 1'b0; ifc.flush = 1'b0; return; end
        end
        tick(); ifc.mem_req_ready = 1'b0; ifc.flush = 1'b0;
        for (int i = 0; i < WNUM; i++) begin
            repeat ((max_gap > 0) ? $urandom_range(max_gap, 0) : 0) tick();
            ifc.mem_resp_valid = 1'b1; ifc.mem_resp_data = exp_line[i];
            ifc.mem_resp_err = (i == err_at); ifc.flush = (i == flush_at);
            n = 0;
            while (1) begin
                @(negedge clk);
                if (ifc.mem_resp_ready) break;
                if (++n > 200) begin timeout("beat"); ifc.mem_resp_valid = 1'b0; return; end
            end
            tick();
            ifc.mem_resp_valid = 1'b0; ifc.mem_resp_err = 1'b0; ifc.flush = 1'b0;
            if (i == abort_after) return;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (ifc.miss_ready !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.ena !== 1'b0 ||
            ifc.refill_err !== 1'b0 || ifc.laddra !== '0 || ifc.tag_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_state: miss_ready=%b req_valid=%b ena=%b err=%b laddra=%h tag=%h, required all 0",
                     ifc.miss_ready, ifc.mem_req_valid, ifc.ena, ifc.refill_err, ifc.laddra, ifc.tag_wdata);
        end
        #11 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifc.miss_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: miss_ready=%b, required 1", ifc.miss_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [AW-1:0] a = 32'h0000_1234;
        int tacc;
        for (int i = 0; i < WNUM; i++) exp_line[i] = DW'(32'hA0 + i);
        clear_mon();
        do_refill(a, 0, 0, -1, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (got_req_addr !== m_line_addr(a) || got_req_addr !== 32'h0000_1220) begin
            n_fail++; $display("FAIL basic_req_addr: got %h, required %h", got_req_addr, m_line_addr(a));
        end
        n_checks++;
        if (t_req_first !== tacc) begin
            n_fail++; $display("FAIL basic_req_latency: first valid cycle %0d, required %0d", t_req_first, tacc);
        end
        n_checks++;
        if (got_idx !== m_idx(a) || got_idx !== 6'h11) begin
            n_fail++; $display("FAIL basic_laddra: got %h, required %h", got_idx, m_idx(a));
        end
        n_checks++;
        if (got_tag !== m_tag(a)) begin
            n_fail++; $display("FAIL basic_tag: got %h, required %h", got_tag, m_tag(a));
        end
        n_checks++;
        if (line_diffs() != 0) begin
            n_fail++; $display("FAIL basic_line: %0d words differ, word0 got %h required %h",
                               line_diffs(), got_line[0], exp_line[0]);
        end
        n_checks++;
        if (n_ena != 1 || n_done != 1 || n_bad_align != 0) begin
            n_fail++; $display("FAIL basic_pulses: ena=%0d done=%0d misaligned=%0d, required 1 1 0",
                               n_ena, n_done, n_bad_align);
        end
        n_checks++;
        if (t_ena != t_last_beat + 1 || t_mr_rise != t_last_beat + 2) begin
            n_fail++; $display("FAIL basic_timing: ena@%0d ready@%0d, required %0d %0d",
                               t_ena, t_mr_rise, t_last_beat + 1, t_last_beat + 2);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a = 32'h0000_1234;
        int tacc;
        for (int i = 0; i < WNUM; i++) exp_line[i] = DW'(32'hA0 + i);
        clear_mon();
        do_refill(a, 5, 3, -1, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_unstable != 0 || n_req_hs != 1 || got_req_addr !== m_line_addr(a)) begin
            n_fail++; $display("FAIL bp_req: unstable=%0d hs=%0d addr=%h, required 0 1 %h",
                               n_unstable, n_req_hs, got_req_addr, m_line_addr(a));
        end
        n_checks++;
        if (n_ena != 1 || n_beats != WNUM || line_diffs() != 0) begin
            n_fail++; $display("FAIL bp_line: ena=%0d beats=%0d diffs=%0d, required 1 %0d 0",
                               n_ena, n_beats, line_diffs(), WNUM);
        end
    endtask

    task automatic test_flush_req();
        int tacc;
        clear_mon();
        do_refill(32'h00AB_CDE0, 0, 0, -2, -1, -1, tacc);
        @(negedge clk);
        n_checks++;
        if (ifc.miss_ready !== 1'b1 || ifc.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_idle: miss_ready=%b req_valid=%b, required 1 0",
                               ifc.miss_ready, ifc.mem_req_valid);
        end
        repeat (4) tick();
        n_checks++;
        if (n_req_hs != 0 || n_ena != 0 || n_err != 0) begin
            n_fail++; $display("FAIL flush_req_quiet: hs=%0d ena=%0d err=%0d, required 0 0 0",
                               n_req_hs, n_ena, n_err);
        end
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(32'h0055_0040, 0, 1, -3, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_req_hs != 1 || n_beats != WNUM || n_ena != 0 || n_done != 0 || n_err != 0) begin
            n_fail++; $display("FAIL flush_hs: hs=%0d beats=%0d ena=%0d done=%0d err=%0d, required 1 %0d 0 0 0",
                               n_req_hs, n_beats, n_ena, n_done, n_err, WNUM);
        end
    endtask

    task automatic test_flush_fill();
        int tacc;
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(32'h1234_5678, 0, 2, 3, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_beats != WNUM || n_ena != 0 || n_err != 0) begin
            n_fail++; $display("FAIL flush_fill: beats=%0d ena=%0d err=%0d, required %0d 0 0",
                               n_beats, n_ena, n_err, WNUM);
        end
        n_checks++;
        if (t_mr_rise != t_last_beat + 1) begin
            n_fail++; $display("FAIL flush_fill_ready: ready@%0d, required %0d", t_mr_rise, t_last_beat + 1);
        end
    endtask

    task automatic test_error();
        logic [AW-1:0] a = 32'hDEAD_BEE0;
        int tacc;
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(a, 1, 1, -1, 5, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_err != 1 || n_ena != 0 || n_done != 0 || n_bad_align != 0) begin
            n_fail++; $display("FAIL err_pulse: err=%0d ena=%0d done=%0d, required 1 0 0", n_err, n_ena, n_done);
        end
        n_checks++;
        if (t_err != t_last_beat + 1 || t_mr_rise != t_last_beat + 1) begin
            n_fail++; $display("FAIL err_timing: err@%0d ready@%0d, required %0d %0d",
                               t_err, t_mr_rise, t_last_beat + 1, t_last_beat + 1);
        end
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(a, 0, 0, -1, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_ena != 1 || n_err != 0 || line_diffs() != 0 || got_tag !== m_tag(a)) begin
            n_fail++; $display("FAIL err_recover: ena=%0d err=%0d diffs=%0d tag=%h, required 1 0 0 %h",
                               n_ena, n_err, line_diffs(), got_tag, m_tag(a));
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [AW-1:0] a = 32'h0BAD_F00C;
        int tacc;
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom | 32'h1;
        clear_mon();
        do_refill(a, 0, 0, -1, -1, 4, tacc);
        rst_n = 1'b0; #1;
        n_checks++;
        if (ifc.miss_ready !== 1'b0 || ifc.mem_resp_ready !== 1'b0 || ifc.ena !== 1'b0 ||
            ifc.laddra !== '0 || ifc.tag_wdata !== '0 || ifc.dina[0] !== '0 || ifc.mem_req_addr !== '0) begin
            n_fail++; $display("FAIL reset_mid_fill: ready=%b resp_ready=%b ena=%b laddra=%h tag=%h dina0=%h, required all 0",
                               ifc.miss_ready, ifc.mem_resp_ready, ifc.ena, ifc.laddra, ifc.tag_wdata, ifc.dina[0]);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(a, 0, 1, -1, -1, -1, tacc);
        repeat (4) tick();
        n_checks++;
        if (n_ena != 1 || line_diffs() != 0 || got_idx !== m_idx(a)) begin
            n_fail++; $display("FAIL reset_recover: ena=%0d diffs=%0d idx=%h, required 1 0 %h",
                               n_ena, line_diffs(), got_idx, m_idx(a));
        end
    endtask

    task automatic test_back_to_back();
        int tacc1, tacc2, last1;
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        clear_mon();
        do_refill(32'h0000_0100, 0, 0, -1, -1, -1, tacc1);
        last1 = t_last_beat;
        for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
        do_refill(32'hFFFF_FFE0, 0, 0, -1, -1, -1, tacc2);
        repeat (4) tick();
        n_checks++;
        if (tacc2 != last1 + 3) begin
            n_fail++; $display("FAIL b2b_accept: second accept@%0d, required %0d", tacc2, last1 + 3);
        end
        n_checks++;
        if (n_ena != 2 || line_diffs() != 0 || got_idx !== m_idx(32'hFFFF_FFE0) || got_tag !== m_tag(32'hFFFF_FFE0)) begin
            n_fail++; $display("FAIL b2b_second: ena=%0d diffs=%0d idx=%h tag=%h, required 2 0 %h %h",
                               n_ena, line_diffs(), got_idx, got_tag, m_idx(32'hFFFF_FFE0), m_tag(32'hFFFF_FFE0));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int tacc, err_at;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            err_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(WNUM - 1, 0)) : -1;
            for (int i = 0; i < WNUM; i++) exp_line[i] = $urandom;
            clear_mon();
            do_refill(a, $urandom_range(3, 0), 2, -1, err_at, -1, tacc);
            repeat (4) tick();
            n_checks++;
            if (got_req_addr !== m_line_addr(a)) begin
                n_fail++; $display("FAIL rand%0d_addr: got %h, required %h", k, got_req_addr, m_line_addr(a));
            end
            n_checks++;
            if (err_at >= 0) begin
                if (n_err != 1 || n_ena != 0) begin
                    n_fail++; $display("FAIL rand%0d_err: err=%0d ena=%0d, required 1 0", k, n_err, n_ena);
                end
            end else if (n_ena != 1 || n_err != 0 || line_diffs() != 0 ||
                         got_idx !== m_idx(a) || got_tag !== m_tag(a)) begin
                n_fail++; $display("FAIL rand%0d_line: ena=%0d err=%0d diffs=%0d idx=%h tag=%h, required 1 0 0 %h %h",
                                   k, n_ena, n_err, line_diffs(), got_idx, got_tag, m_idx(a), m_tag(a));
            end
        end
    endtask

    initial begin
        ifc.miss_valid = 1'b0; ifc.miss_addr = '0; ifc.flush = 1'b0;
        ifc.mem_req_ready = 1'b0; ifc.mem_resp_valid = 1'b0;
        ifc.mem_resp_data = '0; ifc.mem_resp_err = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_req();
        test_flush_fill();
        test_error();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
